// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types and constants for the sequential ALU.
// Holds the opcode and FSM state enums, the flag bit positions and small
// helpers used by the top level. The optional multiplier is controlled by
// the SEQ_ALU_MUL_EN macro in seq_alu.sv.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_NOT = 4'd0,
        OP_AND = 4'd1,
        OP_OR  = 4'd2,
        OP_XOR = 4'd3,
        OP_SHL = 4'd4,
        OP_SHR = 4'd5,
        OP_ROL = 4'd6,
        OP_ROR = 4'd7,
        OP_INC = 4'd8,
        OP_DEC = 4'd9,
        OP_ADD = 4'd10,
        OP_ADC = 4'd11,
        OP_SUB = 4'd12,
        OP_SBB = 4'd13,
        OP_CMP = 4'd14,
        OP_MUL = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int FLG_Z = 0;
    localparam int FLG_S = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                              input logic s, input logic z);
        logic [3:0] f;
        f        = '0;
        f[FLG_V] = v;
        f[FLG_C] = c;
        f[FLG_S] = s;
        f[FLG_Z] = z;
        return f;
    endfunction

    function automatic logic is_shift(input opcode_e o);
        return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROL) || (o == OP_ROR);
    endfunction

endpackage

// File: rtl/seq_alu_addsub.sv
// seq_alu_addsub: combinational WIDTH-bit adder/subtractor with carry-in.
// In subtract mode 'carry' is the borrow (unsigned a < b + cin) and 'ovf' is
// the two's-complement overflow of a - b - cin.
module seq_alu_addsub #(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH:0] ext;

    // Work one bit wider so the extra MSB is the carry-out or the borrow
    always_comb begin
        if (sub) begin
            ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        end else begin
            ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        end
    end

    assign sum   = ext[WIDTH-1:0];
    assign carry = ext[WIDTH];
    assign ovf   = sub ? ((a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]))
                       : (~(a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]));

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes and a persistent
// {V,C,S,Z} flags register. Shifts/rotates iterate one bit per cycle.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier for
// opcode 15; without it opcode 15 completes immediately with err=1.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    // One extra bit so the counter can hold both any shift amount and WIDTH
    localparam int CNT_W = AMT_W + 1;

    state_e             state;
    state_e             next_state;
    opcode_e            op_in;
    opcode_e            op_q;
    logic [AMT_W-1:0]   amt;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               go_shift;
    logic               go_mul;

    logic [WIDTH-1:0]   as_b;
    logic               as_cin;
    logic               as_sub;
    logic [WIDTH-1:0]   as_sum;
    logic               as_carry;
    logic               as_ovf;

    logic [WIDTH-1:0]   sc_result;
    logic [WIDTH-1:0]   sc_val;
    logic               sc_c;
    logic               sc_v;
    logic               sc_err;
    logic [3:0]         sc_flags;

    logic [WIDTH-1:0]   sh_next;
    logic               sh_out;

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
`endif

    assign op_in    = opcode_e'(op);
    assign amt      = b[AMT_W-1:0];
    assign go_shift = is_shift(op_in) && (amt != '0);
`ifdef SEQ_ALU_MUL_EN
    assign go_mul   = (op_in == OP_MUL);
`else
    assign go_mul   = 1'b0;
`endif

    seq_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a     (a),
        .b     (as_b),
        .cin   (as_cin),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry),
        .ovf   (as_ovf)
    );

    // Single-cycle result and flags for the op currently offered at the input
    always_comb begin
        as_b      = b;
        as_cin    = 1'b0;
        as_sub    = 1'b0;
        sc_result = '0;
        sc_val    = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        sc_err    = 1'b0;
        case (op_in)
            OP_NOT: sc_val = ~a;
            OP_AND: sc_val = a & b;
            OP_OR:  sc_val = a | b;
            OP_XOR: sc_val = a ^ b;
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: sc_val = a;
            OP_INC: begin
                as_b = '0; as_cin = 1'b1;
                sc_val = as_sum; sc_c = as_carry; sc_v = as_ovf;
            end
            OP_DEC: begin
                as_b = '0; as_cin = 1'b1; as_sub = 1'b1;
                sc_val = as_sum; sc_c = as_carry; sc_v = as_ovf;
            end
            OP_ADD: begin
                sc_val = as_sum; sc_c = as_carry; sc_v = as_ovf;
            end
            OP_ADC: begin
                as_cin = flags[FLG_C];
                sc_val = as_sum; sc_c = as_carry; sc_v = as_ovf;
            end
            OP_SUB, OP_CMP: begin
                as_sub = 1'b1;
                sc_val = as_sum; sc_c = as_carry; sc_v = as_ovf;
            end
            OP_SBB: begin
                as_sub = 1'b1; as_cin = flags[FLG_C];
                sc_val = as_sum; sc_c = as_carry; sc_v = as_ovf;
            end
`ifndef SEQ_ALU_MUL_EN
            OP_MUL: sc_err = 1'b1;
`endif
            default: sc_err = 1'b0;
        endcase
        // CMP reports flags of the difference but hands back operand a
        sc_result = (op_in == OP_CMP) ? a : sc_val;
        sc_flags  = pack_flags(sc_v, sc_c, sc_val[WIDTH-1], sc_val == '0);
    end

    // One-bit step of the latched shift/rotate and the bit it pushes out
    always_comb begin
        sh_next = acc;
        sh_out  = 1'b0;
        case (op_q)
            OP_SHL: begin sh_next = {acc[WIDTH-2:0], 1'b0};        sh_out = acc[WIDTH-1]; end
            OP_SHR: begin sh_next = {1'b0, acc[WIDTH-1:1]};        sh_out = acc[0];       end
            OP_ROL: begin sh_next = {acc[WIDTH-2:0], acc[WIDTH-1]}; sh_out = acc[WIDTH-1]; end
            OP_ROR: begin sh_next = {acc[0], acc[WIDTH-1:1]};      sh_out = acc[0];       end
            default: sh_next = acc;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    // Partial product after adding the current multiplier bit
    always_comb begin
        prod_next = prod + (mplier[0] ? mcand : '0);
    end
`endif

    // State register; reset aborts any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (go_shift)    next_state = SHIFT;
                    else if (go_mul) next_state = MUL;
                    else             next_state = DONE;
                end
            end
            SHIFT: if (cnt == CNT_W'(1)) next_state = DONE;
`ifdef SEQ_ALU_MUL_EN
            MUL:   if (cnt == CNT_W'(1)) next_state = DONE;
`endif
            DONE:  if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: capture at acceptance, iterate, and commit result/flags on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            flags  <= '0;
            err    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= OP_NOT;
`ifdef SEQ_ALU_MUL_EN
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= op_in;
                        err  <= 1'b0;
                        acc  <= a;
                        cnt  <= CNT_W'(amt);
                        if (!go_shift && !go_mul) begin
                            result <= sc_result;
                            err    <= sc_err;
                            if (!sc_err) flags <= sc_flags;
                        end
`ifdef SEQ_ALU_MUL_EN
                        if (go_mul) begin
                            prod   <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= CNT_W'(WIDTH);
                        end
`endif
                    end
                end
                SHIFT: begin
                    acc <= sh_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result <= sh_next;
                        flags  <= pack_flags(1'b0, sh_out, sh_next[WIDTH-1], sh_next == '0);
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                MUL: begin
                    prod   <= prod_next;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result <= prod_next[WIDTH-1:0];
                        flags  <= pack_flags(|prod_next[2*WIDTH-1:WIDTH],
                                             |prod_next[2*WIDTH-1:WIDTH],
                                             prod_next[WIDTH-1],
                                             prod_next[WIDTH-1:0] == '0);
                    end
                end
`endif
                default: begin
                    result <= result;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=20.
// Expectations follow SEQ_ALU_MUL_EN when that macro is defined.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [19:0] a = '0;
    logic [19:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] result;
    logic [3:0]  flags;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;

    seq_alu #(.WIDTH(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Offer one op, scramble the inputs after acceptance, and count cycles to out_valid
    task automatic issue(input logic [3:0] o, input logic [19:0] x, input logic [19:0] y,
                         output int lat);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'd3; a = 20'hAAAAA; b = 20'h55555;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++; if (result !== 20'h0) begin tests_failed++; $display("[TB] FAIL reset_result: got %h expected 00000", result); end
        tests_run++; if (flags !== 4'h0 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flags_err: got %h/%b expected 0/0", flags, err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        int lat;
        issue(OP_ADD, 20'h7FFFF, 20'h00001, lat);
        tests_run++; if (lat !== 1) begin tests_failed++; $display("[TB] FAIL add_latency: got %0d expected 1", lat); end
        tests_run++; if (result !== 20'h80000) begin tests_failed++; $display("[TB] FAIL add_result: got %h expected 80000", result); end
        tests_run++; if (flags !== 4'b1010 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_flags: got %b/%b expected 1010/0", flags, err); end
        consume();
        issue(OP_SUB, 20'h00003, 20'h00005, lat);
        tests_run++; if (result !== 20'hFFFFE) begin tests_failed++; $display("[TB] FAIL sub_result: got %h expected FFFFE", result); end
        tests_run++; if (flags !== 4'b0110) begin tests_failed++; $display("[TB] FAIL sub_flags: got %b expected 0110", flags); end
        consume();
        issue(OP_SBB, 20'h0000A, 20'h00002, lat);
        tests_run++; if (result !== 20'h00007 || flags !== 4'b0000) begin tests_failed++; $display("[TB] FAIL sbb: got %h/%b expected 00007/0000", result, flags); end
        consume();
        issue(OP_DEC, 20'h80000, 20'h00000, lat);
        tests_run++; if (result !== 20'h7FFFF || flags !== 4'b1000) begin tests_failed++; $display("[TB] FAIL dec_ovf: got %h/%b expected 7FFFF/1000", result, flags); end
        consume();
        issue(OP_CMP, 20'h00005, 20'h00007, lat);
        tests_run++; if (result !== 20'h00005 || flags[FLG_C] !== 1'b1) begin tests_failed++; $display("[TB] FAIL cmp: got %h/C=%b expected 00005/C=1", result, flags[FLG_C]); end
        consume();
    endtask

    task automatic test_logic();
        int lat;
        issue(OP_OR, 20'hF0000, 20'h0000F, lat);
        tests_run++; if (result !== 20'hF000F || flags !== 4'b0010) begin tests_failed++; $display("[TB] FAIL or: got %h/%b expected F000F/0010", result, flags); end
        consume();
        issue(OP_NOT, 20'hFFFFF, 20'h00000, lat);
        tests_run++; if (result !== 20'h00000 || flags !== 4'b0001) begin tests_failed++; $display("[TB] FAIL not: got %h/%b expected 00000/0001", result, flags); end
        consume();
    endtask

    task automatic test_shift();
        int lat;
        issue(OP_SHL, 20'h80001, 20'h00001, lat);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("[TB] FAIL shl_latency: got %0d expected 2", lat); end
        tests_run++; if (result !== 20'h00002 || flags !== 4'b0100) begin tests_failed++; $display("[TB] FAIL shl: got %h/%b expected 00002/0100", result, flags); end
        consume();
        issue(OP_ROR, 20'h00001, 20'h00004, lat);
        tests_run++; if (lat !== 5) begin tests_failed++; $display("[TB] FAIL ror_latency: got %0d expected 5", lat); end
        tests_run++; if (result !== 20'h10000 || flags !== 4'b0000) begin tests_failed++; $display("[TB] FAIL ror: got %h/%b expected 10000/0000", result, flags); end
        consume();
        issue(OP_SHR, 20'h12345, 20'h00000, lat);
        tests_run++; if (lat !== 1 || result !== 20'h12345 || flags !== 4'b0000) begin tests_failed++; $display("[TB] FAIL shr_zero: got lat=%0d %h/%b expected lat=1 12345/0000", lat, result, flags); end
        consume();
        issue(OP_SHR, 20'hFFFFF, 20'h0001F, lat);
        tests_run++; if (lat !== 32 || result !== 20'h00000 || flags !== 4'b0001) begin tests_failed++; $display("[TB] FAIL shr_31: got lat=%0d %h/%b expected lat=32 00000/0001", lat, result, flags); end
        consume();
        issue(OP_ROL, 20'h80000, 20'h00014, lat);
        tests_run++; if (lat !== 21 || result !== 20'h80000 || flags !== 4'b0010) begin tests_failed++; $display("[TB] FAIL rol_20: got lat=%0d %h/%b expected lat=21 80000/0010", lat, result, flags); end
        consume();
    endtask

    task automatic test_back_pressure();
        int lat;
        issue(OP_AND, 20'hF0F0F, 20'h0FF00, lat);
        op = OP_ADD; a = 20'h00001; b = 20'h00001; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 20'h00F00 || flags !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL hold_%0d: got v=%b r=%b %h/%b expected v=1 r=0 00F00/0000", i, out_valid, in_ready, result, flags);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        consume();
        tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(OP_XOR, 20'h12345, 20'h0000F, lat);
        tests_run++; if (result !== 20'h1234A) begin tests_failed++; $display("[TB] FAIL b2b_xor: got %h expected 1234A", result); end
        consume();
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ready: got %b expected 1", in_ready); end
        issue(OP_INC, 20'hFFFFF, 20'h00000, lat);
        tests_run++; if (lat !== 1 || result !== 20'h00000 || flags !== 4'b0101) begin tests_failed++; $display("[TB] FAIL b2b_inc: got lat=%0d %h/%b expected lat=1 00000/0101", lat, result, flags); end
        consume();
    endtask

    task automatic test_mul();
        int lat;
`ifdef SEQ_ALU_MUL_EN
        issue(OP_MUL, 20'h00400, 20'h00400, lat);
        tests_run++; if (lat !== 21) begin tests_failed++; $display("[TB] FAIL mul_latency: got %0d expected 21", lat); end
        tests_run++; if (result !== 20'h00000 || flags !== 4'b1101 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL mul_ovf: got %h/%b/%b expected 00000/1101/0", result, flags, err); end
        consume();
        issue(OP_MUL, 20'h00003, 20'h00005, lat);
        tests_run++; if (result !== 20'h0000F || flags !== 4'b0000) begin tests_failed++; $display("[TB] FAIL mul_small: got %h/%b expected 0000F/0000", result, flags); end
        consume();
`else
        issue(OP_SUB, 20'h00003, 20'h00005, lat);
        consume();
        issue(OP_MUL, 20'h00400, 20'h00400, lat);
        tests_run++; if (lat !== 1) begin tests_failed++; $display("[TB] FAIL mul_latency: got %0d expected 1", lat); end
        tests_run++; if (err !== 1'b1 || result !== 20'h00000 || flags !== 4'b0110) begin tests_failed++; $display("[TB] FAIL mul_err: got %b/%h/%b expected 1/00000/0110", err, result, flags); end
        consume();
        issue(OP_ADD, 20'h00001, 20'h00001, lat);
        tests_run++; if (err !== 1'b0 || result !== 20'h00002) begin tests_failed++; $display("[TB] FAIL err_clear: got %b/%h expected 0/00002", err, result); end
        consume();
`endif
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        issue(OP_SUB, 20'h00003, 20'h00005, lat);
        consume();
        op = OP_SHL; a = 20'h00001; b = 20'h0000F; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_handshake: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); end
        tests_run++; if (result !== 20'h0 || flags !== 4'h0 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_state: got %h/%b/%b expected 00000/0000/0", result, flags, err); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("[TB] FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end
        issue(OP_ADD, 20'h00002, 20'h00003, lat);
        tests_run++; if (lat !== 1 || result !== 20'h00005 || flags !== 4'b0000) begin tests_failed++; $display("[TB] FAIL abort_next_op: got lat=%0d %h/%b expected lat=1 00005/0000", lat, result, flags); end
        consume();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_back_pressure();
        test_back_to_back();
        test_mul();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
